// File: rtl/adder_stager_pkg.sv
// Shared encodings for the adder operand stager: FSM state codes, beat
// indices and the signed-overflow rule applied to a captured sum.
package adder_stager_pkg;

  localparam logic [1:0] S_A    = 2'd0;
  localparam logic [1:0] S_B    = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic BEAT_A = 1'b0;
  localparam logic BEAT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_A    = S_A,
    ST_B    = S_B,
    ST_EXEC = S_EXEC,
    ST_OUT  = S_OUT
  } stager_state_e;

  // Two same-signed operands producing a differently-signed sum overflowed.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_operand_stager.sv
// Valid/ready staging around an external ripple-carry adder: collects A then B,
// captures sum/carry/overflow, and holds the result until taken downstream.
// Optional feature macro: CARRY_CHAIN_EN (adds in_chain and a carry-chain reg).
module adder_operand_stager
  import adder_stager_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
`ifdef CARRY_CHAIN_EN
  input  logic             in_chain,
`endif
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  stager_state_e    state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             ovf_d;
  logic             cin_d;
`ifdef CARRY_CHAIN_EN
  logic             chain_c_q;
`endif

  assign ovf_d = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], add_sum[WIDTH-1]);

`ifdef CARRY_CHAIN_EN
  // A chained B beat continues the previous word's carry-out.
  assign cin_d = in_chain ? chain_c_q : in_cin;
`else
  assign cin_d = in_cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_A;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
`ifdef CARRY_CHAIN_EN
      chain_c_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_A: begin
          if (in_valid) begin
            a_q     <= in_data;
            state_q <= ST_B;
          end
        end
        ST_B: begin
          if (in_valid) begin
            b_q        <= in_data;
            cin_q      <= cin_d;
            in_ready_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_sum_q   <= add_sum;
          out_cout_q  <= add_cout;
          out_ovf_q   <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_A;
`ifdef CARRY_CHAIN_EN
            chain_c_q   <= out_cout_q;
`endif
          end
        end
        default: begin
          state_q     <= ST_A;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = cin_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_operand_stager.sv
// Scoreboard bench for adder_operand_stager with a behavioural adder attached.
module tb_adder_operand_stager;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_cin = 1'b0;
  logic         in_chain = 1'b0;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  adder_operand_stager #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cin   (in_cin),
`ifdef CARRY_CHAIN_EN
    .in_chain (in_chain),
`endif
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_cout", 32'(out_cout), 32'(e.cout));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic c, input logic ch);
    bit ok = 1'b0;
    in_data  = d;
    in_cin   = c;
    in_chain = ch;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic ch, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    exp_t e;
    e.sum = es; e.cout = ec; e.ovf = eo;
    send_beat(a, 1'b0, 1'b0);
    exp_q.push_back(e);
    send_beat(b, c, ch);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    int           n;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_add_ops", 32'({add_a, add_b, add_cin}), 32'd0);
    chk("rst_out_regs", 32'({out_sum, out_cout, out_ovf}), 32'd0);
    @(posedge clk);
    #1;

    // 1: positive overflow, plus latency and operand-port checks
    run_vec(4'h3, 4'h5, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_exec_out_valid", 32'(out_valid), 32'd0);
    chk("exec_in_ready", 32'(in_ready), 32'd0);
    chk("add_a_b", 32'({add_a, add_b}), 32'h35);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // 2, 3: wraparound carry cases
    run_vec(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    wait_drain();
    run_vec(4'h7, 4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    wait_drain();
    // negative overflow: -8 + -1
    run_vec(4'h8, 4'hF, 1'b0, 1'b0, 4'h7, 1'b1, 1'b1);
    wait_drain();

    // 4: backpressure in S_OUT, stray input beats ignored
    out_ready = 1'b0;
    run_vec(4'h6, 4'h4, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    held = out_sum;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 4'hC;
      @(negedge clk);
      chk("bp_out_sum_stable", 32'(out_sum), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_add_a_stable", 32'(add_a), 32'h6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    run_vec(4'h1, 4'h2, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0);
    wait_drain();

    // 5: reset during S_EXEC discards the pending operation
    send_beat(4'h9, 1'b0, 1'b0);
    send_beat(4'h6, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_out_valid", 32'(out_valid), 32'd0);
    chk("rst_exec_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exec_out_sum", 32'(out_sum), 32'd0);
    @(posedge clk);
    #1;
    run_vec(4'h2, 4'h2, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
    wait_drain();

    // 6: multi-word carry chaining
    run_vec(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    wait_drain();
`ifdef CARRY_CHAIN_EN
    run_vec(4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
`else
    run_vec(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
`endif
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
